// File: rtl/reg_lock_scoreboard_pkg.sv
// Shared scoreboard sizing, lock-vector type and lock FSM states.
package maverickOne_pkg;

    localparam int unsigned NUM_REGS        = 32;
    localparam int unsigned NUM_OUTSTANDING = 8;
    localparam int unsigned REG_W           = $clog2(NUM_REGS);
    localparam int unsigned CNT_W           = $clog2(NUM_OUTSTANDING + 1);

    typedef logic [NUM_REGS-1:0] locks_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } lock_state_e;

endpackage

// File: rtl/reg_lock_scoreboard_counter.sv
// Saturating up/down counter for the in-flight instruction count.
// Simultaneous inc and dec cancel; clear has priority over both.
module sat_updown_counter #(
    parameter int unsigned MAX = 8,
    localparam int unsigned W  = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         arst_ni,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] next_count_c_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i && (count_q != W'(MAX))) begin
            count_d = count_q + W'(1);
        end else if (dec_i && !inc_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o        = count_q;
    assign next_count_c_o = count_d;

endmodule

// File: rtl/reg_lock_scoreboard.sv
// Register lock scoreboard: per-register write locks, in-flight count and
// blocking-instruction drain. Optional checker: REG_LOCK_SCOREBOARD_ERR_EN.
module reg_lock_scoreboard
    import maverickOne_pkg::*;
#(
    parameter int unsigned NUM_REGS        = maverickOne_pkg::NUM_REGS,
    parameter int unsigned NUM_OUTSTANDING = maverickOne_pkg::NUM_OUTSTANDING,
    localparam int unsigned RW = $clog2(NUM_REGS),
    localparam int unsigned CW = $clog2(NUM_OUTSTANDING + 1)
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                clear_i,
    input  logic                launch_fire_i,
    input  logic [RW-1:0]       launch_rd_i,
    input  logic                launch_blocking_i,
    input  logic                wb_valid_i,
    input  logic [RW-1:0]       wb_rd_i,
    output logic [NUM_REGS-1:0] locks_o,
    output logic [CW-1:0]       outstanding_o,
    output logic                full_o,
    output logic                error_o
);

    lock_state_e         state_q, state_d;
    logic [NUM_REGS-1:0] lock_q, lock_d;
    logic [CW-1:0]       count, count_next;
    logic                full_c;

    sat_updown_counter #(
        .MAX (NUM_OUTSTANDING)
    ) u_count (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .clear_i        (clear_i),
        .inc_i          (launch_fire_i),
        .dec_i          (wb_valid_i),
        .count_o        (count),
        .next_count_c_o (count_next)
    );

    assign full_c = (count == CW'(NUM_OUTSTANDING));

    // Lock update and drain FSM; a set on the same rd as a writeback wins.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        if (clear_i) begin
            state_d = IDLE;
            lock_d  = '0;
        end else begin
            if (wb_valid_i) begin
                lock_d[wb_rd_i] = 1'b0;
            end
            if (launch_fire_i && (launch_rd_i != '0)) begin
                lock_d[launch_rd_i] = 1'b1;
            end
            unique case (state_q)
                IDLE:  if (launch_fire_i && launch_blocking_i) state_d = BLOCK;
                BLOCK: if (count_next == '0)                   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    assign locks_o       = ((state_q == BLOCK) || full_c) ? '1 : {lock_q[NUM_REGS-1:1], 1'b0};
    assign outstanding_o = count;
    assign full_o        = full_c;

`ifdef REG_LOCK_SCOREBOARD_ERR_EN
    logic error_q, error_d;

    // Sticky protocol checker; only clear or reset drops the flag.
    always_comb begin
        error_d = error_q;
        if (clear_i) begin
            error_d = 1'b0;
        end else if ((launch_fire_i && full_c) ||
                     (wb_valid_i && (count == '0)) ||
                     (wb_valid_i && (wb_rd_i != '0) && !lock_q[wb_rd_i]) ||
                     (launch_fire_i && launch_blocking_i && (state_q == BLOCK))) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_reg_lock_scoreboard.sv
// Self-checking bench for reg_lock_scoreboard: directed table, corner
// sequences and randomized traffic against a behavioural model.
module tb_reg_lock_scoreboard;

    localparam int NR = 32;
    localparam int NO = 8;

    logic        clk_i = 1'b0;
    logic        arst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        launch_fire_i = 1'b0;
    logic [4:0]  launch_rd_i = '0;
    logic        launch_blocking_i = 1'b0;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic [31:0] locks_o;
    logic [3:0]  outstanding_o;
    logic        full_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit [31:0] m_lock;
    int        m_cnt;
    bit        m_block;
    bit        m_err;

    always #5 clk_i = ~clk_i;

    reg_lock_scoreboard dut (
        .clk_i             (clk_i),
        .arst_ni           (arst_ni),
        .clear_i           (clear_i),
        .launch_fire_i     (launch_fire_i),
        .launch_rd_i       (launch_rd_i),
        .launch_blocking_i (launch_blocking_i),
        .wb_valid_i        (wb_valid_i),
        .wb_rd_i           (wb_rd_i),
        .locks_o           (locks_o),
        .outstanding_o     (outstanding_o),
        .full_o            (full_o),
        .error_o           (error_o)
    );

    typedef struct {
        bit          l;
        int          rd;
        bit          blk;
        bit          wb;
        int          wrd;
        bit          clr;
        logic [31:0] e_locks;
        int          e_out;
        bit          e_full;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit l, int rd, bit blk, bit wb, int wrd, bit clr,
                                logic [31:0] el, int eo, bit ef);
        vec_t v;
        v.l = l; v.rd = rd; v.blk = blk; v.wb = wb; v.wrd = wrd; v.clr = clr;
        v.e_locks = el; v.e_out = eo; v.e_full = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_lock = '0; m_cnt = 0; m_block = 1'b0; m_err = 1'b0;
    endfunction

    function automatic void model_update(bit l, int rd, bit blk, bit wb, int wrd, bit clr);
        if (clr) begin
            model_reset();
            return;
        end
`ifdef REG_LOCK_SCOREBOARD_ERR_EN
        if ((l && m_cnt == NO) || (wb && m_cnt == 0) ||
            (wb && wrd != 0 && !m_lock[wrd]) || (l && blk && m_block))
            m_err = 1'b1;
`endif
        if (wb) m_lock[wrd] = 1'b0;
        if (l && rd != 0) m_lock[rd] = 1'b1;
        if (l && !wb && m_cnt < NO) m_cnt = m_cnt + 1;
        if (wb && !l && m_cnt > 0) m_cnt = m_cnt - 1;
        if (m_block) begin
            if (m_cnt == 0) m_block = 1'b0;
        end else if (l && blk) begin
            m_block = 1'b1;
        end
    endfunction

    function automatic logic [31:0] model_locks();
        if (m_block || m_cnt == NO) return '1;
        return m_lock & ~32'h1;
    endfunction

    // Drive one cycle of inputs, advance the model at the edge, sample after it.
    task automatic step(input bit l, input int rd, input bit blk,
                        input bit wb, input int wrd, input bit clr);
        launch_fire_i = l; launch_rd_i = 5'(rd); launch_blocking_i = blk;
        wb_valid_i = wb; wb_rd_i = 5'(wrd); clear_i = clr;
        @(posedge clk_i);
        model_update(l, rd, blk, wb, wrd, clr);
        #1;
        launch_fire_i = 1'b0; wb_valid_i = 1'b0; clear_i = 1'b0; launch_blocking_i = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_locks"}, 64'(locks_o), 64'(model_locks()));
        check({tag, "_out"}, 64'(outstanding_o), 64'(m_cnt));
        check({tag, "_full"}, 64'(full_o), 64'(m_cnt == NO));
        check({tag, "_err"}, 64'(error_o), 64'(m_err));
    endtask

    initial begin
        bit exp_err_full;
        model_reset();

        // Reset held for 10 cycles
        repeat (10) @(posedge clk_i);
        #1;
        check("rst_hold_locks", 64'(locks_o), 64'h0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("rst_locks", 64'(locks_o), 64'h0);
        check("rst_out", 64'(outstanding_o), 64'h0);
        check("rst_full", 64'(full_o), 64'h0);
        check("rst_err", 64'(error_o), 64'h0);

        // Directed table: single lock, same-cycle set/clear, blocking drain, clear in BLOCK
        tbl[0]  = mk(1, 5, 0, 0, 0, 0, 32'h20, 1, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 32'h20, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 5, 0, 32'h0,  0, 0);
        tbl[4]  = mk(1, 7, 0, 0, 0, 0, 32'h80, 1, 0);
        tbl[5]  = mk(1, 7, 0, 1, 7, 0, 32'h80, 1, 0);
        tbl[6]  = mk(0, 0, 0, 1, 7, 0, 32'h0,  0, 0);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 32'h2,  1, 0);
        tbl[8]  = mk(1, 2, 0, 0, 0, 0, 32'h6,  2, 0);
        tbl[9]  = mk(1, 3, 1, 0, 0, 0, 32'hFFFF_FFFF, 3, 0);
        tbl[10] = mk(0, 0, 0, 1, 3, 0, 32'hFFFF_FFFF, 2, 0);
        tbl[11] = mk(0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF, 1, 0);
        tbl[12] = mk(0, 0, 0, 1, 2, 0, 32'h0,  0, 0);
        tbl[13] = mk(1, 4, 1, 0, 0, 0, 32'hFFFF_FFFF, 1, 0);
        tbl[14] = mk(1, 6, 0, 0, 0, 0, 32'hFFFF_FFFF, 2, 0);
        tbl[15] = mk(1, 8, 0, 0, 0, 0, 32'hFFFF_FFFF, 3, 0);
        tbl[16] = mk(1, 9, 0, 0, 0, 0, 32'hFFFF_FFFF, 4, 0);
        tbl[17] = mk(1, 10, 0, 0, 0, 1, 32'h0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].l, tbl[i].rd, tbl[i].blk, tbl[i].wb, tbl[i].wrd, tbl[i].clr);
            check($sformatf("vec%0d_locks", i), 64'(locks_o), 64'(tbl[i].e_locks));
            check($sformatf("vec%0d_out", i), 64'(outstanding_o), 64'(tbl[i].e_out));
            check($sformatf("vec%0d_full", i), 64'(full_o), 64'(tbl[i].e_full));
            check($sformatf("vec%0d_err", i), 64'(error_o), 64'h0);
        end

        // Fill to NUM_OUTSTANDING, then overflow attempt
        for (int r = 1; r <= NO; r++) step(1, r, 0, 0, 0, 0);
        check("full_flag", 64'(full_o), 64'h1);
        check("full_locks", 64'(locks_o), 64'hFFFF_FFFF);
        check("full_out", 64'(outstanding_o), 64'(NO));
        step(1, 9, 0, 0, 0, 0);
`ifdef REG_LOCK_SCOREBOARD_ERR_EN
        exp_err_full = 1'b1;
`else
        exp_err_full = 1'b0;
`endif
        check("ovf_out", 64'(outstanding_o), 64'(NO));
        check("ovf_err", 64'(error_o), 64'(exp_err_full));
        step(0, 0, 0, 0, 0, 1);
        check("ovf_clear_err", 64'(error_o), 64'h0);
        check("ovf_clear_out", 64'(outstanding_o), 64'h0);

        // Asynchronous reset in the middle of BLOCK
        step(1, 11, 1, 0, 0, 0);
        step(1, 12, 0, 0, 0, 0);
        check("pre_rst_block", 64'(locks_o), 64'hFFFF_FFFF);
        #2 arst_ni = 1'b0;
        #1;
        model_reset();
        check("midrst_locks", 64'(locks_o), 64'h0);
        check("midrst_out", 64'(outstanding_o), 64'h0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        @(posedge clk_i); #1;
        check_model("postrst");

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            bit l, blk, wb, clr;
            int rd, wrd;
            l   = ($urandom_range(99) < 50);
            blk = ($urandom_range(99) < 5);
            wb  = ($urandom_range(99) < 45);
            clr = ($urandom_range(199) == 0);
            rd  = $urandom_range(NR - 1);
            wrd = $urandom_range(NR - 1);
            if (m_lock != 0 && $urandom_range(9) < 8) begin
                for (int k = 0; k < 64; k++) begin
                    wrd = $urandom_range(NR - 1);
                    if (m_lock[wrd]) break;
                end
            end
            step(l, rd, blk, wb, wrd, clr);
            check_model($sformatf("rnd%0d", c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
